// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and req/ready instruction-memory handshake.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        PC_WriteEnable,
   input  logic        IFIDWriteEnable,
   input  logic        IFIDFlush,
   input  logic        Branch,
   input  logic        Jump,
   input  logic [31:0] BranchDest,
   input  logic [31:0] JumpDest,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemReady,
   input  logic [31:0] IMemRdata,
   output logic [31:0] Instruction_Out,
   output logic [31:0] PC_Out,
   output logic        IFID_JFlush
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount
`endif
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic {F_FETCH, F_HOLD} fstate_t;

   fstate_t         state_q, state_nxt;
   logic [XLEN-1:0] pc_q, pc_nxt;
   logic [XLEN-1:0] hold_q, hold_nxt;
   logic [XLEN-1:0] instr_nxt, ifpc_nxt;
   logic            jflush_nxt, req_nxt;

   logic            stall, redirect, fetch_ok;
   logic            load_v, bubble_v;
   logic [XLEN-1:0] load_word, pc_inc, npc_raw, npc;

   assign stall    = ~(PC_WriteEnable & IFIDWriteEnable);
   assign redirect = (Branch | Jump) & PC_WriteEnable;
   // Only a response to a request actually on the bus counts (ignores stale data after reset).
   assign fetch_ok = IMemReq & IMemReady;
   assign pc_inc   = (pc_q + XLEN'(4)) & ALIGN_MASK;
   assign npc_raw  = Jump ? JumpDest : (Branch ? BranchDest : pc_inc);
   assign npc      = npc_raw & ALIGN_MASK;
   assign IMemAddr = pc_q;

   // Next-state, next-PC and IF/ID contents
   always_comb begin
      state_nxt  = state_q;
      pc_nxt     = pc_q;
      hold_nxt   = hold_q;
      instr_nxt  = Instruction_Out;
      ifpc_nxt   = PC_Out;
      jflush_nxt = IFID_JFlush;
      load_v     = 1'b0;
      bubble_v   = 1'b0;
      load_word  = hold_q;

      if (redirect) begin
         pc_nxt    = npc;
         state_nxt = F_FETCH;
         bubble_v  = 1'b1;
      end else begin
         case (state_q)
            F_FETCH: begin
               if (fetch_ok) begin
                  if (stall || IFIDFlush) begin
                     // Keep the word so a flush or stall never forces a refetch
                     hold_nxt  = IMemRdata;
                     state_nxt = F_HOLD;
                  end else begin
                     load_v    = 1'b1;
                     load_word = IMemRdata;
                     pc_nxt    = pc_inc;
                  end
               end
            end
            F_HOLD: begin
               if (!stall && !IFIDFlush) begin
                  load_v    = 1'b1;
                  load_word = hold_q;
                  pc_nxt    = pc_inc;
                  state_nxt = F_FETCH;
               end
            end
            default: state_nxt = F_FETCH;
         endcase
         if (!load_v && (IFIDFlush || IFIDWriteEnable)) begin
            bubble_v = 1'b1;
         end
      end

      if (load_v) begin
         instr_nxt  = load_word;
         ifpc_nxt   = pc_q;
         jflush_nxt = 1'b0;
      end else if (bubble_v) begin
         instr_nxt  = NOP_INSTR;
         ifpc_nxt   = pc_q;
         jflush_nxt = 1'b1;
      end

      req_nxt = (state_nxt == F_FETCH);
   end

   // State, PC and IF/ID registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q         <= F_FETCH;
         pc_q            <= RESET_PC;
         hold_q          <= '0;
         IMemReq         <= 1'b0;
         Instruction_Out <= NOP_INSTR;
         PC_Out          <= RESET_PC;
         IFID_JFlush     <= 1'b1;
      end else begin
         state_q         <= state_nxt;
         pc_q            <= pc_nxt;
         hold_q          <= hold_nxt;
         IMemReq         <= req_nxt;
         Instruction_Out <= instr_nxt;
         PC_Out          <= ifpc_nxt;
         IFID_JFlush     <= jflush_nxt;
      end
   end

`ifdef IF_PERF_CNT_EN
   // A flush bubble comes from either a redirect or IFIDFlush; a load never coincides with either
   logic flush_ev;
   assign flush_ev = redirect | IFIDFlush;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         FetchCount <= '0;
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (load_v)          FetchCount <= FetchCount + XLEN'(1);
         if (!PC_WriteEnable) StallCount <= StallCount + XLEN'(1);
         if (flush_ev)        FlushCount <= FlushCount + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, stall/hold, branch, jump priority, wait states, redirect in hold,
// reset mid-wait, IFIDFlush with held word, and PC wrap.
module tb_if_stage;

   logic        Clock = 1'b0;
   logic        Reset, PC_WriteEnable, IFIDWriteEnable, IFIDFlush, Branch, Jump;
   logic [31:0] BranchDest, JumpDest;
   logic        IMemReq, IMemReady, IFID_JFlush;
   logic [31:0] IMemAddr, IMemRdata, Instruction_Out, PC_Out;

   int n_checks = 0;
   int n_pass   = 0;
   int wait_n   = 0;
   int wcnt     = 0;

   localparam logic [31:0] TAG = 32'hA500_0000;
   localparam logic [31:0] NOP = 32'h0000_0000;

   if_stage dut (
      .Clock(Clock), .Reset(Reset),
      .PC_WriteEnable(PC_WriteEnable), .IFIDWriteEnable(IFIDWriteEnable), .IFIDFlush(IFIDFlush),
      .Branch(Branch), .Jump(Jump), .BranchDest(BranchDest), .JumpDest(JumpDest),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemRdata(IMemRdata),
      .Instruction_Out(Instruction_Out), .PC_Out(PC_Out), .IFID_JFlush(IFID_JFlush)
   );

   always #5 Clock = ~Clock;

   // Memory model: word content is a tag xor'd with the address; ready after wait_n waiting cycles
   assign IMemRdata = TAG ^ IMemAddr;
   assign IMemReady = (wcnt >= wait_n);
   always @(posedge Clock) wcnt <= (IMemReq && !IMemReady) ? wcnt + 1 : 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic jf);
      check({tag, ".instr"}, Instruction_Out, instr);
      check({tag, ".pc"}, PC_Out, pc);
      check({tag, ".jf"}, 32'(IFID_JFlush), 32'(jf));
   endtask

   initial begin
      Reset = 1'b0; PC_WriteEnable = 1'b1; IFIDWriteEnable = 1'b1; IFIDFlush = 1'b0;
      Branch = 1'b0; Jump = 1'b0; BranchDest = '0; JumpDest = '0;

      // T1 reset and streaming fetch
      step(); step();
      check("rst.req", 32'(IMemReq), 32'd0);
      chk_ifid("rst", NOP, 32'h0, 1'b1);
      Reset = 1'b1;
      step();
      check("t1.req", 32'(IMemReq), 32'd1);
      check("t1.addr0", IMemAddr, 32'h0);
      step();
      check("t1.addr4", IMemAddr, 32'h4);
      chk_ifid("t1.w0", TAG ^ 32'h0, 32'h0, 1'b0);
      step();
      check("t1.addr8", IMemAddr, 32'h8);
      chk_ifid("t1.w4", TAG ^ 32'h4, 32'h4, 1'b0);

      // T2 load-use stall at PC=8
      PC_WriteEnable = 1'b0; IFIDWriteEnable = 1'b0;
      step();
      check("t2.req", 32'(IMemReq), 32'd0);
      check("t2.addr", IMemAddr, 32'h8);
      chk_ifid("t2.hold", TAG ^ 32'h4, 32'h4, 1'b0);
      step();
      check("t2.addr2", IMemAddr, 32'h8);
      chk_ifid("t2.hold2", TAG ^ 32'h4, 32'h4, 1'b0);
      PC_WriteEnable = 1'b1; IFIDWriteEnable = 1'b1;
      step();
      chk_ifid("t2.rel", TAG ^ 32'h8, 32'h8, 1'b0);
      check("t2.req1", 32'(IMemReq), 32'd1);
      check("t2.addrC", IMemAddr, 32'hC);
      step();
      chk_ifid("t2.wC", TAG ^ 32'hC, 32'hC, 1'b0);

      // T3 taken branch at PC=0x10
      Branch = 1'b1; BranchDest = 32'h40;
      step();
      Branch = 1'b0;
      check("t3.addr", IMemAddr, 32'h40);
      chk_ifid("t3.bub", NOP, 32'h10, 1'b1);
      step();
      chk_ifid("t3.w40", TAG ^ 32'h40, 32'h40, 1'b0);

      // T4 jump wins over branch; jump target alignment
      Jump = 1'b1; JumpDest = 32'h100; Branch = 1'b1; BranchDest = 32'h80;
      step();
      check("t4.prio", IMemAddr, 32'h100);
      Branch = 1'b0; JumpDest = 32'h103;
      step();
      Jump = 1'b0;
      check("t4.align", IMemAddr, 32'h100);
      chk_ifid("t4.bub", NOP, 32'h100, 1'b1);
      step();
      chk_ifid("t4.w100", TAG ^ 32'h100, 32'h100, 1'b0);

      // T5 three wait states per fetch
      wait_n = 3;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t5.jf%0d", i), 32'(IFID_JFlush), 32'd1);
         check($sformatf("t5.addr%0d", i), IMemAddr, 32'h104);
      end
      step();
      chk_ifid("t5.w104", TAG ^ 32'h104, 32'h104, 1'b0);

      // T6 redirect while holding a word
      wait_n = 0;
      PC_WriteEnable = 1'b0; IFIDWriteEnable = 1'b0;
      step();
      check("t6.hold", 32'(IMemReq), 32'd0);
      PC_WriteEnable = 1'b1; IFIDWriteEnable = 1'b1; Jump = 1'b1; JumpDest = 32'h200;
      step();
      Jump = 1'b0;
      check("t6.addr", IMemAddr, 32'h200);
      chk_ifid("t6.bub", NOP, 32'h108, 1'b1);
      step();
      chk_ifid("t6.w200", TAG ^ 32'h200, 32'h200, 1'b0);

      // Reset while a fetch is waiting; a late ready must be ignored
      wait_n = 3;
      step(); step();
      Reset = 1'b0;
      step();
      check("rmw.req", 32'(IMemReq), 32'd0);
      check("rmw.addr", IMemAddr, 32'h0);
      chk_ifid("rmw", NOP, 32'h0, 1'b1);
      wait_n = 0;
      Reset = 1'b1;
      step();
      chk_ifid("rmw.late", NOP, 32'h0, 1'b1);
      check("rmw.addr2", IMemAddr, 32'h0);
      step();
      chk_ifid("rmw.w0", TAG ^ 32'h0, 32'h0, 1'b0);

      // IFIDFlush forces a bubble but keeps the fetched word
      IFIDFlush = 1'b1; IFIDWriteEnable = 1'b0;
      step();
      IFIDFlush = 1'b0; IFIDWriteEnable = 1'b1;
      chk_ifid("fl.bub", NOP, 32'h4, 1'b1);
      check("fl.addr", IMemAddr, 32'h4);
      step();
      chk_ifid("fl.w4", TAG ^ 32'h4, 32'h4, 1'b0);
      check("fl.addr8", IMemAddr, 32'h8);

      // PC wrap at top of address space
      Jump = 1'b1; JumpDest = 32'hFFFF_FFFC;
      step();
      Jump = 1'b0;
      check("wr.addr", IMemAddr, 32'hFFFF_FFFC);
      step();
      check("wr.wrap", IMemAddr, 32'h0);
      chk_ifid("wr.wtop", TAG ^ 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
